cnt_run_arbiter: RTL and testbench
==================================

# cnt_run_arbiter

- Round-robin arbiter and sequencer that shares one 4-bit run counter between `N_REQ` requesters.
- The run counter behaves as follows:
  - increments on `start`;
  - then self-increments from 1 to 5;
  - returns to 0 the cycle after showing 5;
  - clears on `clr`.
- This block grants one requester at a time and issues the single-cycle `start` only while the counter is idle.
- It watches `cnt_q` through the run and returns a per-requester `done` pulse when the run finishes.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `WDOG_CYCLES`, default 16: maximum cycles allowed in RUN+DONE before abort. Used only with the watchdog compiled in.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  level requests; held until the matching `gnt` bit rises.
- `gnt`  out  N_REQ  one-hot grant, registered; held from START through DONE.
- `done`  out  N_REQ  one-cycle completion pulse to the grantee.
- `err`  out  N_REQ  one-cycle abort pulse to the grantee when the watchdog fires.
- `busy`  out  1  high in any state other than IDLE.
- `cnt_start`  out  1  drives counter `start`.
- `cnt_clr`  out  1  drives counter `clr`.
- `cnt_q`  in  4  counter value.

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE:
  - If `cnt_q != 0`, assert `cnt_clr` (combinational from state and `cnt_q`) and grant nothing.
  - Else, if `|req`, pick the winner by scanning from `rr_ptr` upward modulo `N_REQ`. The first set bit wins.
  - Register `gnt` = one-hot(winner) and go to START.
- START: `cnt_start` = 1 for exactly this cycle. Go to RUN.
- RUN: when `cnt_q == 5`, go to DONE. All other values keep RUN.
- DONE:
  - `done` = `gnt` for this cycle.
  - Next cycle: `gnt` clears, `rr_ptr` = winner+1 (wrapping at `N_REQ`), state returns to IDLE.
- Dropping `req` after grant has no effect. The run completes and `done` still pulses.
- A requester that still holds `req` after `done` is re-arbitrated with lowest priority.
- `cnt_start` is never asserted when `cnt_q != 0`, and never in two consecutive cycles.
- Simultaneous requests: exactly one grant. No grant-less cycle is skipped beyond the protocol latency below.
- Reset (any state, including mid-run):
  - Next cycle: state IDLE, `rr_ptr` = 0, and `gnt`, `done`, `err`, `busy`, `cnt_start`, `cnt_clr` all 0.
  - The counter shares `rst_n` and resets to 0 in the same cycle.

## Timing
- Requests sampled at edge T in IDLE with `cnt_q == 0`:
  - `gnt` and `busy` high in cycle T+1.
  - `cnt_start` high in cycle T+1 only.
- Counter values: `cnt_q` = 1 at T+2, 2 at T+3, 3 at T+4, 4 at T+5, 5 at T+6, 0 at T+7.
- DONE occupies T+7: `done` pulses, `cnt_q` = 0.
- T+8: `gnt` low, IDLE. Next request is sampled at the T+8 edge; its grant is high at T+9.
- Back-to-back period is 8 cycles per run.
- Request-to-done latency is 7 cycles.
- Idle recovery: `cnt_q != 0` in IDLE costs one `cnt_clr` cycle before any grant.

## Configuration
- Macro: `CNT_RUN_ARBITER_WDOG_EN`.
- Defined:
  - A watchdog counter (width `$clog2(WDOG_CYCLES+1)`) clears in START and increments each cycle in RUN/DONE.
  - On reaching `WDOG_CYCLES`, assert `cnt_clr` for one cycle and pulse `err` = `gnt` in place of `done`.
  - Then clear `gnt`, advance `rr_ptr` as for normal completion, and return to IDLE.
- Undefined:
  - No watchdog logic; `err` is tied to 0.
  - RUN waits indefinitely for `cnt_q == 5`.

## Test plan
- Single requester: `req` = 4'b0001 at T → `gnt[0]` T+1..T+7, `cnt_start` at T+1 only, `done[0]` at T+7, `cnt_q` sequence 1..5 then 0.
- Contention: `req` = 4'b1010 held, `rr_ptr` = 0 → grant order 1, 3, 1, 3. Grants start 8 cycles apart; `done` pulses alternate.
- Full load: `req` = 4'b1111 held for 32 cycles → grants 0, 1, 2, 3 in order, each for 7 cycles. `gnt` is never multi-hot.
- Dirty idle: force `cnt_q` = 3 in IDLE with `req[2]` high → `cnt_clr` for one cycle, no grant, then grant 2 once `cnt_q == 0`.
- Reset mid-run: `rst_n` low at T+4 of a run → all outputs 0 next cycle. After release, `req[1]` is granted first because `rr_ptr` = 0 and `req[0]` is low.
- Watchdog (macro defined, `WDOG_CYCLES` = 16): hold `cnt_q` at 2 after start → `err[0]` pulse and `cnt_clr` high 16 cycles after START, `done` stays 0, IDLE the next cycle.

Source files
------------

// File: rtl/cnt_run_arbiter.sv
// cnt_run_arbiter: round-robin owner of a shared 1..5 run counter.
// Optional watchdog abort: define CNT_RUN_ARBITER_WDOG_EN.
module cnt_run_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] err,
  output logic             busy,
  output logic             cnt_start,
  output logic             cnt_clr,
  input  logic [3:0]       cnt_q
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_cfg_err
    $error("cnt_run_arbiter: bad N_REQ or WDOG_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [PW-1:0]    pick;
  logic             pick_vld;
  logic [PW-1:0]    next_ptr;
  logic             cnt_idle;
  logic             run_end;
  logic             abort;

  assign cnt_idle = (cnt_q == 4'd0);
  assign run_end  = (cnt_q == 4'd5);

`ifdef CNT_RUN_ARBITER_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state_q == S_START) begin
      wd_q <= '0;
    end else if (state_q == S_RUN || state_q == S_DONE) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // fires on the WDOG_CYCLES-th cycle after START
  assign abort = (state_q == S_RUN) && !run_end &&
                 (wd_q == WW'(WDOG_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  always_comb begin : p_arb
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_vld && req[j[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = j[PW-1:0];
      end
    end
  end

  assign next_ptr = (win_q == PW'(N_REQ - 1)) ? '0
                  : win_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    win_d     = win_q;
    cnt_start = 1'b0;
    cnt_clr   = 1'b0;
    done      = '0;
    err       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!cnt_idle) begin
          cnt_clr = 1'b1;
        end else if (pick_vld) begin
          gnt_d   = N_REQ'(1) << pick;
          win_d   = pick;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (run_end) begin
          state_d = S_DONE;
        end else if (abort) begin
          cnt_clr = 1'b1;
          err     = gnt_q;
          gnt_d   = '0;
          rr_d    = next_ptr;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        done    = gnt_q;
        gnt_d   = '0;
        rr_d    = next_ptr;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnt_run_arbiter.sv
// tb_cnt_run_arbiter: scoreboard bench with a behavioural run counter.
// Watchdog scenario included when CNT_RUN_ARBITER_WDOG_EN is defined.
module tb_cnt_run_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt, done, err;
  logic       busy, cnt_start, cnt_clr;
  logic [3:0] cnt_q;

  logic       ld = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] ld_val = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    byte        kind;
    logic [3:0] val;
    int         at;
  } ev_t;

  ev_t q[$];

  always #5 clk = ~clk;

  cnt_run_arbiter #(.N_REQ(4), .WDOG_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .cnt_start (cnt_start),
    .cnt_clr   (cnt_clr),
    .cnt_q     (cnt_q)
  );

  // shared run counter: start -> 1..5 -> 0, clr wins
  always @(posedge clk) begin
    if (!rst_n)                            cnt_q <= '0;
    else if (cnt_clr)                      cnt_q <= '0;
    else if (ld)                           cnt_q <= ld_val;
    else if (hold)                         cnt_q <= cnt_q;
    else if (cnt_start)                    cnt_q <= cnt_q + 4'd1;
    else if (cnt_q != 0 && cnt_q < 4'd5)   cnt_q <= cnt_q + 4'd1;
    else                                   cnt_q <= '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(byte k, logic [3:0] v, int at);
    q.push_back('{k, v, at});
  endtask

  task automatic exp_run(int idx, int t);
    exp_ev("G", 4'(1 << idx), t + 1);
    exp_ev("S", 4'd0, t + 1);
    exp_ev("D", 4'(1 << idx), t + 7);
  endtask

  task automatic got(byte k, logic [3:0] v);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      $display("FAIL ev_%c unexpected at cyc %0d val %b", k, cyc, v);
    end else begin
      e = q.pop_front();
      if (e.kind == k && e.val == v && e.at == cyc) begin
        n_pass++;
      end else begin
        $display("FAIL ev got %c/%b/cyc%0d required %c/%b/cyc%0d",
                 k, v, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  bit         mon_en = 1'b0;
  logic [3:0] prev_gnt = '0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if ((busy == (|gnt)) && $onehot0(gnt) &&
          !(cnt_start && (cnt_q != 0 || prev_start))) begin
        n_pass++;
      end else begin
        $display("FAIL invariant cyc %0d: gnt=%b busy=%b start=%b cnt=%0d prev_start=%b",
                 cyc, gnt, busy, cnt_start, cnt_q, prev_start);
      end
      if (gnt != 0 && gnt != prev_gnt) got("G", gnt);
      if (cnt_start)                   got("S", 4'd0);
      if (done != 0)                   got("D", done);
      if (err != 0)                    got("E", err);
      if (cnt_clr)                     got("C", 4'd0);
      prev_gnt   = gnt;
      prev_start = cnt_start;
    end
  end

  task automatic chk_zero(string name);
    n_chk++;
    if ({gnt, done, err, busy, cnt_start, cnt_clr, cnt_q} == '0) begin
      n_pass++;
    end else begin
      $display("FAIL %s: gnt=%b done=%b err=%b busy=%b start=%b clr=%b cnt=%0d required all 0",
               name, gnt, done, err, busy, cnt_start, cnt_clr, cnt_q);
    end
  endtask

  task automatic run_single(int idx);
    int t;
    t   = cyc;
    req = 4'(1 << idx);
    exp_run(idx, t);
    step();
    req = '0;
    repeat (7) step();
  endtask

  task automatic run_held(logic [3:0] r, int a, int b, int c, int d);
    int t;
    t   = cyc;
    req = r;
    exp_run(a, t);
    exp_run(b, t + 8);
    exp_run(c, t + 16);
    exp_run(d, t + 24);
    repeat (26) step();
    req = '0;
    repeat (6) step();
  endtask

  initial begin
    int t;
    repeat (2) step();
    chk_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    run_single(0);

    run_held(4'b1010, 1, 3, 1, 3);

    run_held(4'b1111, 0, 1, 2, 3);

    t      = cyc;
    ld_val = 4'd3;
    ld     = 1'b1;
    step();
    ld  = 1'b0;
    req = 4'b0100;
    exp_ev("C", 4'd0, t + 1);
    exp_run(2, t + 2);
    step();
    step();
    req = '0;
    repeat (7) step();

    t   = cyc;
    req = 4'b0001;
    exp_ev("G", 4'b0001, t + 1);
    exp_ev("S", 4'd0, t + 1);
    step();
    req = '0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk_zero("reset_mid_run");
    rst_n = 1'b1;
    req   = 4'b1110;
    exp_run(1, t + 5);
    step();
    req = '0;
    repeat (7) step();

`ifdef CNT_RUN_ARBITER_WDOG_EN
    t   = cyc;
    req = 4'b0001;
    exp_ev("G", 4'b0001, t + 1);
    exp_ev("S", 4'd0, t + 1);
    exp_ev("E", 4'b0001, t + 17);
    exp_ev("C", 4'd0, t + 17);
    step();
    req = '0;
    repeat (2) step();
    hold = 1'b1;
    repeat (14) step();
    hold = 1'b0;
    step();
    n_chk++;
    if (!busy && gnt == '0) n_pass++;
    else $display("FAIL wdog_idle: busy=%b gnt=%b required 0", busy, gnt);
`endif

    repeat (3) step();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d events outstanding required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
